block_map_responder: RTL and testbench



---
 rtl/block_map_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_block_map_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_map_responder.sv
// Brick-map responder: 1-cycle cell reads, hit / stage-load / stage-select requests.
// Define BLOCK_MAP_SCORE_EN to add the saturating bm_score output.
module block_map_responder #(
    parameter int ROWS = 30,
    parameter int COLS = 10,
    parameter int CW   = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          bm_enable,
    input  logic [1:0]    bm_func,
    input  logic [1:0]    bm_stage,
    input  logic [4:0]    bm_row,
    input  logic [4:0]    bm_col,
    output logic [3:0]    bm_block,
    output logic          bm_ready,
    output logic [CW-1:0] bm_remaining,
    output logic          bm_cleared,
`ifdef BLOCK_MAP_SCORE_EN
    output logic [15:0]   bm_score,
`endif
    output logic [1:0]    sel_stage
);

    localparam int RW = $clog2(ROWS);
    localparam int XW = $clog2(COLS);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    map_q [ROWS][COLS];
    logic [3:0]    block_q, block_d;
    logic          ready_q, ready_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic          cleared_q, cleared_d;
    logic [1:0]    sel_q, sel_d;
    logic [4:0]    lra_row_q, lra_row_d;
    logic [4:0]    lra_col_q, lra_col_d;
    logic [RW-1:0] ld_row_q, ld_row_d;
    logic [XW-1:0] ld_col_q, ld_col_d;
    logic [1:0]    ld_stage_q, ld_stage_d;
`ifdef BLOCK_MAP_SCORE_EN
    logic [15:0]   score_q, score_d;
    logic [16:0]   score_sum;
`endif

    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [XW-1:0] wr_col;
    logic [3:0]    wr_val;

    logic          rd_ok, lra_ok, hit_ok, hit_kill, ld_last;
    logic [3:0]    rd_val, lra_val, ld_val;
    logic [1:0]    hit_hp;

    // Built-in stage layouts, evaluated per cell during a load scan
    function automatic logic [3:0] stage_cell(
        input logic [1:0] s,
        input int         r,
        input int         c
    );
        logic [1:0] hp;
        hp = (r[1:0] == 2'd0) ? 2'd3 : r[1:0];
        stage_cell = 4'd0;
        unique case (s)
            2'd0: if (r >= 2 && r <= 5) stage_cell = 4'b0001;
            2'd1: if (r >= 2 && r <= 7 && r[0] == c[0]) stage_cell = 4'b0010;
            2'd2: if (r >= 2 && r <= 9) stage_cell = {1'b0, ~c[0], hp};
            2'd3: begin
                if (r >= 2 && r <= 6)
                    stage_cell = 4'b0011;
                else if (r == 8 && (c == 0 || c == COLS - 1))
                    stage_cell = 4'b1001;
            end
        endcase
    endfunction

    assign rd_ok   = (int'(bm_row) < ROWS) && (int'(bm_col) < COLS);
    assign rd_val  = rd_ok ? map_q[bm_row[RW-1:0]][bm_col[XW-1:0]] : 4'd0;
    assign lra_ok  = (int'(lra_row_q) < ROWS) && (int'(lra_col_q) < COLS);
    assign lra_val = lra_ok ? map_q[lra_row_q[RW-1:0]][lra_col_q[XW-1:0]] : 4'd0;
    assign hit_ok  = lra_ok && !lra_val[3] && (lra_val[1:0] != 2'd0);
    assign hit_hp  = lra_val[1:0] - 2'd1;
    assign hit_kill = hit_ok && (hit_hp == 2'd0);
    assign ld_val  = stage_cell(ld_stage_q, int'(ld_row_q), int'(ld_col_q));
    assign ld_last = (int'(ld_row_q) == ROWS - 1) && (int'(ld_col_q) == COLS - 1);

    // Next-state: read path, request decode and the load scan
    always_comb begin
        state_d     = state_q;
        block_d     = 4'd0;
        ready_d     = ready_q;
        remaining_d = remaining_q;
        cleared_d   = 1'b0;
        sel_d       = sel_q;
        lra_row_d   = lra_row_q;
        lra_col_d   = lra_col_q;
        ld_row_d    = ld_row_q;
        ld_col_d    = ld_col_q;
        ld_stage_d  = ld_stage_q;
        wr_en       = 1'b0;
        wr_row      = ld_row_q;
        wr_col      = ld_col_q;
        wr_val      = ld_val;
`ifdef BLOCK_MAP_SCORE_EN
        score_d     = score_q;
        score_sum   = 17'd0;
`endif
        unique case (state_q)
            IDLE: begin
                block_d   = rd_val;
                lra_row_d = bm_row;
                lra_col_d = bm_col;
                ready_d   = 1'b1;
                if (bm_enable) begin
                    unique case (bm_func)
                        2'b00: begin
                            if (hit_ok) begin
                                wr_en  = 1'b1;
                                wr_row = lra_row_q[RW-1:0];
                                wr_col = lra_col_q[XW-1:0];
                                wr_val = hit_kill ? 4'd0 : {lra_val[3:2], hit_hp};
                                if (hit_kill && remaining_q != '0) begin
                                    remaining_d = remaining_q - CW'(1);
                                    cleared_d   = (remaining_q == CW'(1));
                                end
`ifdef BLOCK_MAP_SCORE_EN
                                score_sum = {1'b0, score_q} + 17'd1
                                          + (hit_kill ? (lra_val[2] ? 17'd8 : 17'd4) : 17'd0);
                                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                            end
                        end
                        2'b01: begin
                            state_d     = LOAD;
                            ready_d     = 1'b0;
                            block_d     = 4'd0;
                            remaining_d = '0;
                            ld_row_d    = '0;
                            ld_col_d    = '0;
                            ld_stage_d  = (bm_stage == 2'b11) ? sel_q : bm_stage;
                            lra_row_d   = '1;
                            lra_col_d   = '1;
`ifdef BLOCK_MAP_SCORE_EN
                            score_d     = 16'd0;
`endif
                        end
                        2'b10: sel_d = sel_q - 2'd1;
                        2'b11: sel_d = sel_q + 2'd1;
                    endcase
                end
            end
            LOAD: begin
                wr_en     = 1'b1;
                lra_row_d = '1;
                lra_col_d = '1;
                if (ld_val[1:0] != 2'd0 && !ld_val[3])
                    remaining_d = remaining_q + CW'(1);
                if (ld_last) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else if (int'(ld_col_q) == COLS - 1) begin
                    ld_col_d = '0;
                    ld_row_d = ld_row_q + RW'(1);
                end else begin
                    ld_col_d = ld_col_q + XW'(1);
                end
            end
        endcase
    end

    // State, output and map registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            block_q     <= 4'd0;
            ready_q     <= 1'b1;
            remaining_q <= '0;
            cleared_q   <= 1'b0;
            sel_q       <= 2'd0;
            lra_row_q   <= '1;
            lra_col_q   <= '1;
            ld_row_q    <= '0;
            ld_col_q    <= '0;
            ld_stage_q  <= 2'd0;
`ifdef BLOCK_MAP_SCORE_EN
            score_q     <= 16'd0;
`endif
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    map_q[r][c] <= 4'd0;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            ready_q     <= ready_d;
            remaining_q <= remaining_d;
            cleared_q   <= cleared_d;
            sel_q       <= sel_d;
            lra_row_q   <= lra_row_d;
            lra_col_q   <= lra_col_d;
            ld_row_q    <= ld_row_d;
            ld_col_q    <= ld_col_d;
            ld_stage_q  <= ld_stage_d;
`ifdef BLOCK_MAP_SCORE_EN
            score_q     <= score_d;
`endif
            if (wr_en)
                map_q[wr_row][wr_col] <= wr_val;
        end
    end

    assign bm_block     = block_q;
    assign bm_ready     = ready_q;
    assign bm_remaining = remaining_q;
    assign bm_cleared   = cleared_q;
    assign sel_stage    = sel_q;
`ifdef BLOCK_MAP_SCORE_EN
    assign bm_score     = score_q;
`endif

endmodule

// File: tb/tb_block_map_responder.sv
// Bench for block_map_responder: directed scenarios plus random requests,
// every cycle compared against a whole-map behavioural model.
module tb_block_map_responder;

    localparam int ROWS  = 30;
    localparam int COLS  = 10;
    localparam int CW    = 9;
    localparam int NCELL = ROWS * COLS;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          bm_enable = 1'b0;
    logic [1:0]    bm_func = 2'd0;
    logic [1:0]    bm_stage = 2'd0;
    logic [4:0]    bm_row = 5'd0;
    logic [4:0]    bm_col = 5'd0;
    logic [3:0]    bm_block;
    logic          bm_ready;
    logic [CW-1:0] bm_remaining;
    logic          bm_cleared;
    logic [1:0]    sel_stage;
`ifdef BLOCK_MAP_SCORE_EN
    logic [15:0]   bm_score;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_cell [ROWS][COLS];
    int m_busy = 0;
    int m_sel = 0;
    int m_lra_r = 0;
    int m_lra_c = 0;
    bit m_lra_ok = 1'b0;
    int e_block = 0;
    bit e_cleared = 1'b0;
    int m_score = 0;

    always #5 clock = ~clock;

    block_map_responder #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .clock(clock),
        .reset(reset),
        .bm_enable(bm_enable),
        .bm_func(bm_func),
        .bm_stage(bm_stage),
        .bm_row(bm_row),
        .bm_col(bm_col),
        .bm_block(bm_block),
        .bm_ready(bm_ready),
        .bm_remaining(bm_remaining),
        .bm_cleared(bm_cleared),
`ifdef BLOCK_MAP_SCORE_EN
        .bm_score(bm_score),
`endif
        .sel_stage(sel_stage)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pat(input int s, input int r, input int c);
        case (s)
            0: return (r >= 2 && r <= 5) ? 1 : 0;
            1: return (r >= 2 && r <= 7 && (r + c) % 2 == 0) ? 2 : 0;
            2: begin
                if (r >= 2 && r <= 9)
                    return ((c % 2 == 0) ? 4 : 0) + ((r % 4 == 0) ? 3 : r % 4);
                return 0;
            end
            default: begin
                if (r >= 2 && r <= 6) return 3;
                if (r == 8 && (c == 0 || c == COLS - 1)) return 9;
                return 0;
            end
        endcase
    endfunction

    function automatic bit in_range(input int r, input int c);
        return r < ROWS && c < COLS;
    endfunction

    function automatic int remaining_count();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_cell[r][c] % 4 != 0 && m_cell[r][c] < 8) n++;
        return n;
    endfunction

    task automatic model_step();
        int r, c, pre, v, tgt;
        e_cleared = 1'b0;
        if (reset) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) m_cell[i][j] = 0;
            m_busy = 0; m_sel = 0; m_lra_ok = 1'b0; e_block = 0; m_score = 0;
            return;
        end
        if (m_busy > 0) begin
            m_busy--; e_block = 0; m_lra_ok = 1'b0;
            return;
        end
        r = int'(bm_row);
        c = int'(bm_col);
        pre = in_range(r, c) ? m_cell[r][c] : 0;
        if (bm_enable) begin
            case (bm_func)
                2'b00: begin
                    if (m_lra_ok && in_range(m_lra_r, m_lra_c)) begin
                        v = m_cell[m_lra_r][m_lra_c];
                        if (v % 4 != 0 && v < 8) begin
                            m_score += 1;
                            if (v % 4 == 1) begin
                                m_cell[m_lra_r][m_lra_c] = 0;
                                m_score += (v >= 4) ? 8 : 4;
                                if (remaining_count() == 0) e_cleared = 1'b1;
                            end else begin
                                m_cell[m_lra_r][m_lra_c] = v - 1;
                            end
                            if (m_score > 65535) m_score = 65535;
                        end
                    end
                end
                2'b01: begin
                    tgt = (bm_stage == 2'b11) ? m_sel : int'(bm_stage);
                    for (int i = 0; i < ROWS; i++)
                        for (int j = 0; j < COLS; j++) m_cell[i][j] = pat(tgt, i, j);
                    m_busy = NCELL; e_block = 0; m_lra_ok = 1'b0; m_score = 0;
                    return;
                end
                2'b10: m_sel = (m_sel + 3) % 4;
                default: m_sel = (m_sel + 1) % 4;
            endcase
        end
        e_block = pre;
        m_lra_r = r; m_lra_c = c; m_lra_ok = 1'b1;
    endtask

    task automatic cycle(input bit en, input logic [1:0] f, input logic [1:0] st,
                         input int r, input int c);
        bm_enable = en; bm_func = f; bm_stage = st;
        bm_row = 5'(r); bm_col = 5'(c);
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("block", bm_block, e_block);
        chk("ready", bm_ready, (m_busy == 0));
        chk("cleared", bm_cleared, e_cleared);
        chk("sel_stage", sel_stage, m_sel);
        if (m_busy == 0) chk("remaining", bm_remaining, remaining_count());
`ifdef BLOCK_MAP_SCORE_EN
        chk("score", bm_score, m_score);
`endif
    endtask

    task automatic idle(input int r = 0, input int c = 0);
        cycle(1'b0, 2'b00, 2'b00, r, c);
    endtask

    task automatic hit(input int r, input int c);
        cycle(1'b1, 2'b00, 2'b00, r, c);
    endtask

    task automatic load(input logic [1:0] st);
        cycle(1'b1, 2'b01, st, 0, 0);
    endtask

    task automatic wait_load();
        repeat (NCELL) idle();
        chk("ready_after_load", bm_ready, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    initial begin
        int x, en, f, st, r, c;
        do_reset();

        idle(3, 4);
        chk("rst_block", bm_block, 0);
        chk("rst_ready", bm_ready, 1);
        chk("rst_remaining", bm_remaining, 0);
        chk("rst_sel", sel_stage, 0);

        load(2'b00);
        chk("load_busy", bm_ready, 0);
        wait_load();
        chk("s0_remaining", bm_remaining, 40);
        idle(2, 0);
        chk("s0_cell_2_0", bm_block, 1);
        idle(6, 0);
        chk("s0_cell_6_0", bm_block, 0);

        idle(2, 3);
        hit(2, 3);
        idle(2, 3);
        chk("hit_cell", bm_block, 0);
        chk("hit_remaining", bm_remaining, 39);
        hit(2, 3);
        idle(2, 3);
        chk("rehit_cell", bm_block, 0);
        chk("rehit_remaining", bm_remaining, 39);

        cycle(1'b1, 2'b10, 2'b00, 0, 0);
        chk("sel_to_3", sel_stage, 3);
        load(2'b11);
        wait_load();
        chk("s3_remaining", bm_remaining, 50);
        idle(8, 0);
        hit(8, 0);
        idle(8, 0);
        chk("indestructible", bm_block, 4'b1001);
        idle(2, 0);
        hit(2, 0);
        chk("hp_seq_3", bm_block, 4'b0011);
        hit(2, 0);
        chk("hp_seq_2", bm_block, 4'b0010);
        hit(2, 0);
        chk("hp_seq_1", bm_block, 4'b0001);
        hit(2, 0);
        chk("hp_seq_0", bm_block, 4'b0000);
        chk("s3_hit_remaining", bm_remaining, 49);

        do_reset();
        cycle(1'b1, 2'b10, 2'b00, 0, 0);
        chk("sel_wrap_down", sel_stage, 3);
        cycle(1'b1, 2'b11, 2'b00, 0, 0);
        cycle(1'b1, 2'b11, 2'b00, 0, 0);
        chk("sel_wrap_up", sel_stage, 1);
        load(2'b11);
        wait_load();
        idle(2, 0);
        chk("s1_cell_2_0", bm_block, 4'b0010);
        idle(2, 1);
        chk("s1_cell_2_1", bm_block, 0);
        chk("s1_remaining", bm_remaining, 30);

        load(2'b00);
        wait_load();
        for (int rr = 2; rr <= 5; rr++)
            for (int cc = 0; cc < COLS; cc++) begin
                idle(rr, cc);
                hit(rr, cc);
            end
        chk("cleared_pulse", bm_cleared, 1);
        chk("cleared_remaining", bm_remaining, 0);
        idle();
        chk("cleared_once", bm_cleared, 0);

        load(2'b10);
        repeat (99) idle();
        do_reset();
        chk("abort_ready_rst", bm_ready, 1);
        idle();
        chk("abort_ready", bm_ready, 1);
        chk("abort_remaining", bm_remaining, 0);
        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++) idle(rr, cc);

        load(2'b10);
        wait_load();
        repeat (2500) begin
            en = int'($urandom_range(0, 1));
            x = int'($urandom_range(0, 99));
            f = (x < 70) ? 0 : (x < 72) ? 1 : (x < 86) ? 2 : 3;
            st = int'($urandom_range(0, 3));
            r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, ROWS - 1));
            c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, COLS - 1));
            cycle(en[0], 2'(f), 2'(st), r, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
